// File: rtl/adc_sample_capture_if.sv
// adc_sample_capture_if: ADC serial bus plus sample handshake between capture stage and arithmetic control
interface adc_sample_capture_if #(parameter int OUT_W = 16);
  logic enable;
  logic sdata;
  logic resultado_listo;
  logic cs_n;
  logic sclk;
  logic [OUT_W-1:0] sample;
  logic dato_listo;
  logic overrun;
  modport master (
    input  enable, sdata, resultado_listo,
    output cs_n, sclk, sample, dato_listo, overrun
  );
  modport slave (
    output enable, sdata, resultado_listo,
    input  cs_n, sclk, sample, dato_listo, overrun
  );
endinterface

// File: rtl/adc_sample_capture.sv
// adc_sample_capture: periodic AD7476-style serial ADC capture producing signed samples with overrun tracking
module adc_sample_capture #(
  parameter int CLK_DIV       = 4,
  parameter int SAMPLE_PERIOD = 2268,
  parameter int OUT_W         = 16
) (
  input logic clk,
  input logic reset,
  adc_sample_capture_if.master bus
);
  localparam int CW = $clog2(SAMPLE_PERIOD);
  localparam int DW = $clog2(CLK_DIV) + 1;
  localparam logic [CW-1:0] LAST  = CW'(SAMPLE_PERIOD - 1);
  localparam logic [DW-1:0] DLAST = DW'(CLK_DIV - 1);
  typedef enum logic [1:0] {IDLE, CS_SETUP, SHIFT, DONE} state_t;
  state_t state;
  logic [CW-1:0] count;
  logic [DW-1:0] div;
  logic [3:0] bits;
  logic [11:0] shift;
  logic pending;
  logic tick;
  assign tick = bus.enable && count == '0;
  always_ff @(posedge clk or posedge reset)
    if (reset) count <= '0;
    else count <= (!bus.enable || count == LAST) ? '0 : count + 1'b1;
  // Leading-zero bits fall off the top of the 12-bit register, leaving the code aligned.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state          <= IDLE;
      div            <= '0;
      bits           <= '0;
      shift          <= '0;
      bus.cs_n       <= 1'b1;
      bus.sclk       <= 1'b1;
      bus.sample     <= '0;
      bus.dato_listo <= 1'b0;
    end else begin
      bus.dato_listo <= 1'b0;
      case (state)
        IDLE: if (tick) begin
          state    <= CS_SETUP;
          bus.cs_n <= 1'b0;
          div      <= '0;
        end
        CS_SETUP: if (div == DLAST) begin
          state    <= SHIFT;
          bus.sclk <= 1'b0;
          div      <= '0;
          bits     <= '0;
        end else div <= div + 1'b1;
        SHIFT: if (div != DLAST) div <= div + 1'b1;
        else begin
          div <= '0;
          if (!bus.sclk) begin
            bus.sclk <= 1'b1;
            shift    <= {shift[10:0], bus.sdata};
          end else if (bits == 4'd15) begin
            state          <= DONE;
            bus.cs_n       <= 1'b1;
            bus.dato_listo <= 1'b1;
            bus.sample     <= OUT_W'({~shift[11], shift[10:0]}) << (OUT_W - 12);
          end else begin
            bus.sclk <= 1'b0;
            bits     <= bits + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      pending     <= 1'b0;
      bus.overrun <= 1'b0;
    end else begin
      if (bus.dato_listo && pending && !bus.resultado_listo) bus.overrun <= 1'b1;
      pending <= bus.dato_listo | (pending & ~bus.resultado_listo);
    end
endmodule
